// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the 5-stage CPU pipeline.
// Hazard FSM encodings, register-zero and NOP/bubble constants.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOADUSE = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_FLUSH   = 2'd3
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic pipe_hold;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_HOLD = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t CTRL_BR   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_LU   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush,
// data-memory wait freeze, plus saturating stall/flush statistics.
module hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs_ID_i,
    input  logic [4:0]       rt_ID_i,
    input  logic             useRt_ID_i,
    input  logic [4:0]       rt_EX_i,
    input  logic             MemRead_EX_i,
    input  logic             BranchTaken_MEM_i,
    input  logic             MemReq_MEM_i,
    input  logic             MemReady_i,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Flush_o,
    output logic             EXMEM_Flush_o,
    output logic             PipeHold_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_timeout_o
);

    localparam logic [15:0] WAIT_LIM = 16'(MAX_WAIT);

    hz_state_e   state_q;
    hz_state_e   state_d;
    hz_ctrl_t    ctrl;
    hz_ctrl_t    ctrl_out;
    logic        mw;
    logic        br;
    logic        lu;
    logic [15:0] wait_q;

    always_comb begin
        mw = MemReq_MEM_i & ~MemReady_i;
        br = BranchTaken_MEM_i;
        // IF/ID holds a flushed NOP right after a branch flush
        lu = MemRead_EX_i
           & (rt_EX_i != REG_ZERO)
           & ((rt_EX_i == rs_ID_i) | (useRt_ID_i & (rt_EX_i == rt_ID_i)))
           & (state_q != ST_FLUSH);
        ctrl    = CTRL_RUN;
        state_d = ST_RUN;
        if (mw) begin
            ctrl    = CTRL_HOLD;
            state_d = ST_MEMWAIT;
        end else if (br) begin
            ctrl    = CTRL_BR;
            state_d = ST_FLUSH;
        end else if (lu) begin
            ctrl    = CTRL_LU;
            state_d = ST_LOADUSE;
        end
        ctrl_out = rst_i ? ctrl : CTRL_RUN;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Timeout is sticky; the access itself is never aborted
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_q        <= '0;
            mem_timeout_o <= 1'b0;
        end else if (mw) begin
            if (wait_q != WAIT_LIM) begin
                wait_q <= wait_q + 16'd1;
            end
            if (wait_q == WAIT_LIM - 16'd1) begin
                mem_timeout_o <= 1'b1;
            end
        end else begin
            wait_q <= '0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(~ctrl_out.pc_write),
        .clr_i(1'b0),
        .cnt_o(stall_cnt_o)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(ctrl_out.exmem_flush),
        .clr_i(1'b0),
        .cnt_o(flush_cnt_o)
    );

    assign PCWrite_o     = ctrl_out.pc_write;
    assign IFID_Write_o  = ctrl_out.ifid_write;
    assign IFID_Flush_o  = ctrl_out.ifid_flush;
    assign IDEX_Flush_o  = ctrl_out.idex_flush;
    assign EXMEM_Flush_o = ctrl_out.exmem_flush;
    assign PipeHold_o    = ctrl_out.pipe_hold;
    assign state_o       = state_q;

endmodule
